pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It consumes the hazard and branch decisions produced in decode, plus instruction- and data-memory ready handshakes, and drives the pipeline registers. Its outputs are the PC write enable, the PC source select, and per-register write-enable and clear (bubble) strobes. It also tracks per-stage valid bits, holds a pending redirect across instruction-memory wait states, and keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipe_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline sequencing controller for the five-stage core. It turns the decode
//   hazard/branch decisions and the memory ready handshakes into PC and
//   pipeline-register controls. It also tracks per-stage valid bits, holds a
//   redirect target across instruction-memory wait states, and counts stall
//   and flush cycles with saturating counters.
//
// Parameters
//   CNT_W         width of each performance counter
// Ports
//   clk           core clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   hz_stall      load-use stall request from decode
//   branch_taken  conditional branch in decode resolved taken
//   jump          JAL/JALR in decode
//   branch_tgt    redirect target, valid with branch_taken or jump
//   imem_ready    fetch data valid this cycle
//   dmem_req      MEM-stage instruction is a load or store
//   dmem_ready    data memory completes the MEM-stage access this cycle
//   pc_we         PC register load enable
//   pc_sel        0: PC+4, 1: redirect_pc
//   redirect_pc   target driven to the PC mux
//   *_we / *_clr  pipeline register enables / bubble strobes (clr wins)
//   valid_*       stage holds a real instruction
//   stall_cnt     saturating count of load-use and data-wait cycles
//   flush_cnt     saturating count of redirect flush cycles
// ----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hz_stall,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic [31:0]      branch_tgt,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [31:0]      redirect_pc,
   output logic             fe_de_we,
   output logic             de_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             fe_de_clr,
   output logic             de_ex_clr,
   output logic             valid_de,
   output logic             valid_ex,
   output logic             valid_mem,
   output logic             valid_wb,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {ST_RUN, ST_IWAIT, ST_RPEND, ST_DWAIT} state_t;

   state_t             state_reg, state_next;
   state_t             ret_reg, ret_next;   // state to resume after a data wait
   state_t             eff_state;
   logic [31:0]        pend_reg, pend_next;
   logic               valid_de_reg, valid_ex_reg, valid_mem_reg, valid_wb_reg;
   logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;
   logic               stall_inc, flush_inc;
   logic               dwait_cond, redirect;

   assign dwait_cond = dmem_req & valid_mem_reg & ~dmem_ready;
   assign redirect   = (branch_taken | jump) & valid_de_reg;
   // The cycle a data wait ends, the pipe behaves as in the state it left.
   assign eff_state  = (state_reg == ST_DWAIT) ? ret_reg : state_reg;

   always_comb begin
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      redirect_pc = branch_tgt;
      fe_de_we    = 1'b0;
      de_ex_we    = 1'b0;
      ex_mem_we   = 1'b0;
      mem_wb_we   = 1'b0;
      fe_de_clr   = 1'b0;
      de_ex_clr   = 1'b0;
      state_next  = state_reg;
      ret_next    = ret_reg;
      pend_next   = pend_reg;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (!rst_n) begin
         // Hold bubbles in the front of the pipe while reset is asserted.
         fe_de_clr = 1'b1;
         de_ex_clr = 1'b1;
      end else if (dwait_cond) begin
         // Whole pipe frozen; remember where to resume only on entry.
         state_next = ST_DWAIT;
         ret_next   = (state_reg == ST_DWAIT) ? ret_reg : state_reg;
         stall_inc  = 1'b1;
      end else if (eff_state == ST_RPEND) begin
         // Decode holds a bubble here, so hazards and redirects cannot apply.
         fe_de_clr   = 1'b1;
         pc_sel      = 1'b1;
         redirect_pc = pend_reg;
         de_ex_we    = 1'b1;
         ex_mem_we   = 1'b1;
         mem_wb_we   = 1'b1;
         pc_we       = imem_ready;
         state_next  = imem_ready ? ST_RUN : ST_RPEND;
      end else if (hz_stall) begin
         // Redirect ignored; the branch re-resolves once the stall clears.
         de_ex_clr  = 1'b1;
         ex_mem_we  = 1'b1;
         mem_wb_we  = 1'b1;
         stall_inc  = 1'b1;
         state_next = imem_ready ? ST_RUN : ST_IWAIT;
      end else if (redirect && imem_ready) begin
         pc_we      = 1'b1;
         pc_sel     = 1'b1;
         fe_de_clr  = 1'b1;
         de_ex_we   = 1'b1;
         ex_mem_we  = 1'b1;
         mem_wb_we  = 1'b1;
         flush_inc  = 1'b1;
         state_next = ST_RUN;
      end else if (redirect) begin
         // Fetch still outstanding: park the target until it returns.
         pend_next  = branch_tgt;
         fe_de_clr  = 1'b1;
         de_ex_we   = 1'b1;
         ex_mem_we  = 1'b1;
         mem_wb_we  = 1'b1;
         flush_inc  = 1'b1;
         state_next = ST_RPEND;
      end else if (!imem_ready) begin
         fe_de_clr  = 1'b1;
         de_ex_we   = 1'b1;
         ex_mem_we  = 1'b1;
         mem_wb_we  = 1'b1;
         state_next = ST_IWAIT;
      end else begin
         pc_we      = 1'b1;
         fe_de_we   = 1'b1;
         de_ex_we   = 1'b1;
         ex_mem_we  = 1'b1;
         mem_wb_we  = 1'b1;
         state_next = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_RUN;
         ret_reg       <= ST_RUN;
         pend_reg      <= '0;
         valid_de_reg  <= 1'b0;
         valid_ex_reg  <= 1'b0;
         valid_mem_reg <= 1'b0;
         valid_wb_reg  <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         ret_reg   <= ret_next;
         pend_reg  <= pend_next;

         if (fe_de_clr)     valid_de_reg  <= 1'b0;
         else if (fe_de_we) valid_de_reg  <= 1'b1;
         if (de_ex_clr)     valid_ex_reg  <= 1'b0;
         else if (de_ex_we) valid_ex_reg  <= valid_de_reg;
         if (ex_mem_we)     valid_mem_reg <= valid_ex_reg;
         if (mem_wb_we)     valid_wb_reg  <= valid_mem_reg;

         if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}}))
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

   assign valid_de  = valid_de_reg;
   assign valid_ex  = valid_ex_reg;
   assign valid_mem = valid_mem_reg;
   assign valid_wb  = valid_wb_reg;
   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl built with 4-bit counters so saturation is
//   reachable. Each task drives one scenario and compares against hand-derived
//   values; inputs change 1 time unit after a rising edge, combinational
//   outputs are sampled 1 unit later, registered state 1 unit after the edge.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             hz_stall, branch_taken, jump;
   logic [31:0]      branch_tgt;
   logic             imem_ready, dmem_req, dmem_ready;
   logic             pc_we, pc_sel;
   logic [31:0]      redirect_pc;
   logic             fe_de_we, de_ex_we, ex_mem_we, mem_wb_we;
   logic             fe_de_clr, de_ex_clr;
   logic             valid_de, valid_ex, valid_mem, valid_wb;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .branch_taken(branch_taken),
      .jump(jump), .branch_tgt(branch_tgt), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .pc_sel(pc_sel),
      .redirect_pc(redirect_pc), .fe_de_we(fe_de_we), .de_ex_we(de_ex_we),
      .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .fe_de_clr(fe_de_clr),
      .de_ex_clr(de_ex_clr), .valid_de(valid_de), .valid_ex(valid_ex),
      .valid_mem(valid_mem), .valid_wb(valid_wb), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hz_stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; branch_tgt = 32'h0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic fill();
      imem_ready = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #2;
      checks++; if ({pc_we, fe_de_we, de_ex_we, ex_mem_we, mem_wb_we} !== 5'b0) begin errors++; $display("FAIL reset_we got %b want 00000", {pc_we, fe_de_we, de_ex_we, ex_mem_we, mem_wb_we}); end
      checks++; if ({fe_de_clr, de_ex_clr} !== 2'b11) begin errors++; $display("FAIL reset_clr got %b want 11", {fe_de_clr, de_ex_clr}); end
      tick();
      checks++; if ({valid_de, valid_ex, valid_mem, valid_wb} !== 4'b0) begin errors++; $display("FAIL reset_valid got %b want 0000", {valid_de, valid_ex, valid_mem, valid_wb}); end
      checks++; if ({stall_cnt, flush_cnt} !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h want 00", {stall_cnt, flush_cnt}); end
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_fill();
      logic [3:0] exp_valid [4];
      exp_valid[0] = 4'b1000; exp_valid[1] = 4'b1100;
      exp_valid[2] = 4'b1110; exp_valid[3] = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL fill_pc_we cyc=%0d got %b want 1", i, pc_we); end
         tick();
         checks++; if ({valid_de, valid_ex, valid_mem, valid_wb} !== exp_valid[i]) begin errors++; $display("FAIL fill_valid cyc=%0d got %b want %b", i + 1, {valid_de, valid_ex, valid_mem, valid_wb}, exp_valid[i]); end
      end
      $display("test_fill done");
   endtask

   task automatic test_branch();
      branch_taken = 1'b1; branch_tgt = 32'h0000_0100;
      #1;
      checks++; if ({pc_sel, pc_we, fe_de_clr} !== 3'b111) begin errors++; $display("FAIL branch_ctl got %b want 111", {pc_sel, pc_we, fe_de_clr}); end
      checks++; if (redirect_pc !== 32'h0000_0100) begin errors++; $display("FAIL branch_tgt got %h want 00000100", redirect_pc); end
      tick();
      branch_taken = 1'b0;
      checks++; if ({valid_de, valid_ex} !== 2'b01) begin errors++; $display("FAIL branch_valid got %b want 01", {valid_de, valid_ex}); end
      checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL branch_flush got %0d want 1", flush_cnt); end
      $display("test_branch done");
   endtask

   task automatic test_stall_jump();
      do_reset();
      fill();
      hz_stall = 1'b1; jump = 1'b1; branch_tgt = 32'h0000_0300;
      #1;
      checks++; if ({pc_we, pc_sel, fe_de_clr, de_ex_clr, ex_mem_we} !== 5'b00011) begin errors++; $display("FAIL stall_ctl got %b want 00011", {pc_we, pc_sel, fe_de_clr, de_ex_clr, ex_mem_we}); end
      tick();
      checks++; if ({valid_de, valid_ex, valid_mem} !== 3'b101) begin errors++; $display("FAIL stall_valid got %b want 101", {valid_de, valid_ex, valid_mem}); end
      hz_stall = 1'b0;
      #1;
      checks++; if ({pc_we, pc_sel, fe_de_clr} !== 3'b111) begin errors++; $display("FAIL jump_ctl got %b want 111", {pc_we, pc_sel, fe_de_clr}); end
      tick();
      jump = 1'b0;
      checks++; if ({stall_cnt, flush_cnt} !== 8'h11) begin errors++; $display("FAIL stall_jump_cnt got %h want 11", {stall_cnt, flush_cnt}); end
      $display("test_stall_jump done");
   endtask

   task automatic test_rpend();
      do_reset();
      fill();
      jump = 1'b1; branch_tgt = 32'h0000_0200; imem_ready = 1'b0;
      #1;
      checks++; if ({pc_we, fe_de_clr} !== 2'b01) begin errors++; $display("FAIL rpend_entry got %b want 01", {pc_we, fe_de_clr}); end
      tick();
      jump = 1'b0; branch_tgt = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if ({pc_we, pc_sel, fe_de_clr} !== 3'b011 || redirect_pc !== 32'h200) begin errors++; $display("FAIL rpend_wait cyc=%0d got %b/%h want 011/00000200", i, {pc_we, pc_sel, fe_de_clr}, redirect_pc); end
         tick();
      end
      imem_ready = 1'b1;
      #1;
      checks++; if ({pc_we, pc_sel, fe_de_clr} !== 3'b111 || redirect_pc !== 32'h200) begin errors++; $display("FAIL rpend_exit got %b/%h want 111/00000200", {pc_we, pc_sel, fe_de_clr}, redirect_pc); end
      tick();
      checks++; if ({pc_we, pc_sel, fe_de_clr} !== 3'b100) begin errors++; $display("FAIL rpend_run got %b want 100", {pc_we, pc_sel, fe_de_clr}); end
      checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL rpend_flush got %0d want 1", flush_cnt); end
      $display("test_rpend done");
   endtask

   task automatic test_dwait();
      do_reset();
      fill();
      imem_ready = 1'b0;
      tick();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if ({pc_we, fe_de_we, de_ex_we, ex_mem_we, mem_wb_we, fe_de_clr, de_ex_clr} !== 7'b0) begin errors++; $display("FAIL dwait_freeze cyc=%0d got %b want 0000000", i, {pc_we, fe_de_we, de_ex_we, ex_mem_we, mem_wb_we, fe_de_clr, de_ex_clr}); end
         tick();
      end
      checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL dwait_stall_cnt got %0d want 4", stall_cnt); end
      dmem_ready = 1'b1;
      #1;
      checks++; if ({pc_we, fe_de_clr, de_ex_we, mem_wb_we} !== 4'b0111) begin errors++; $display("FAIL dwait_resume got %b want 0111", {pc_we, fe_de_clr, de_ex_we, mem_wb_we}); end
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
      #1;
      checks++; if ({pc_we, fe_de_we, fe_de_clr} !== 3'b110) begin errors++; $display("FAIL dwait_iwait_exit got %b want 110", {pc_we, fe_de_we, fe_de_clr}); end
      checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL dwait_cnt_hold got %0d want 4", stall_cnt); end
      tick();
      $display("test_dwait done");
   endtask

   task automatic test_saturate();
      do_reset();
      fill();
      hz_stall = 1'b1;
      repeat (15) tick();
      checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", stall_cnt); end
      repeat (5) tick();
      checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
      checks++; if (valid_de !== 1'b1) begin errors++; $display("FAIL sat_valid_de got %b want 1", valid_de); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if ({stall_cnt, flush_cnt} !== 8'h00) begin errors++; $display("FAIL async_rst_cnt got %h want 00", {stall_cnt, flush_cnt}); end
      checks++; if ({valid_de, valid_ex, valid_mem, valid_wb} !== 4'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0000", {valid_de, valid_ex, valid_mem, valid_wb}); end
      checks++; if ({pc_we, fe_de_clr, de_ex_clr} !== 3'b011) begin errors++; $display("FAIL async_rst_ctl got %b want 011", {pc_we, fe_de_clr, de_ex_clr}); end
      tick();
      rst_n = 1'b1; hz_stall = 1'b0;
      #1;
      checks++; if ({pc_we, pc_sel, fe_de_clr} !== 3'b100) begin errors++; $display("FAIL post_rst_run got %b want 100", {pc_we, pc_sel, fe_de_clr}); end
      tick();
      checks++; if (valid_de !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", valid_de); end
      $display("test_saturate done");
   endtask

   initial begin
      test_reset();
      test_fill();
      test_branch();
      test_stall_jump();
      test_rpend();
      test_dwait();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
